// File: rtl/adc3664_spi_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adc3664_spi_master_pkg
// Purpose  : Shared frame geometry, state encoding and frame builder for the
//            ADC3664 SPI configuration master.
// Revision : 1.0 - initial release
// ============================================================================
package adc3664_spi_master_pkg;

    localparam int FRAME_BITS = 24;
    localparam int ADDR_BITS  = 12;
    localparam int DATA_BITS  = 8;
    localparam int BCNT_BITS  = 5;
    localparam int DIV_BITS   = 8;
    localparam logic RW_READ  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_TRAIL = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    // Assemble the on-wire frame: rw, three zero bits, address, data byte.
    // Read frames carry zeros in the data slot.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic                 rw,
        input logic [ADDR_BITS-1:0] addr,
        input logic [DATA_BITS-1:0] wdata
    );
        logic [DATA_BITS-1:0] payload;
        payload     = (rw == RW_READ) ? {DATA_BITS{1'b0}} : wdata;
        build_frame = {rw, 3'b000, addr, payload};
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc3664_spi_clkgen.sv
`default_nettype none
// ============================================================================
// Module   : adc3664_spi_clkgen
// Purpose  : Half-period timer. Emits a tick every CLK_DIV enabled cycles and
//            splits it into rise/fall strobes according to the current SCLK.
// Revision : 1.0 - initial release
// ============================================================================
module adc3664_spi_clkgen
    import adc3664_spi_master_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic en,
    input  logic sclk,
    output logic tick,
    output logic rise,
    output logic fall
);

    localparam logic [DIV_BITS-1:0] c_reload = DIV_BITS'(CLK_DIV - 1);

    logic [DIV_BITS-1:0] r_cnt;

    // Count enabled cycles; restart from zero whenever disabled or at terminal count.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cnt <= '0;
        end else if (!en || (r_cnt == c_reload)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = en && (r_cnt == c_reload);
    assign rise = tick && !sclk;
    assign fall = tick && sclk;

endmodule
`default_nettype wire

// File: rtl/adc3664_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : adc3664_spi_master
// Purpose  : 24-bit 3-wire SPI master for ADC3664 register access. Writes
//            shift a full frame; reads turn SDIO around after the 16-bit
//            header and capture the returned byte into rdata.
// Revision : 1.0 - initial release
// ============================================================================
module adc3664_spi_master
    import adc3664_spi_master_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 start,
    input  logic                 rw,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_BITS-1:0] wdata,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 SCLK,
    output logic                 SEN,
    output logic                 SDIO_out,
    output logic                 SDIO_oe,
    input  logic                 SDIO_in
);

    state_t                  r_state,   w_state;
    logic [FRAME_BITS-1:0]   r_sreg,    w_sreg;
    logic [BCNT_BITS-1:0]    r_bit_cnt, w_bit_cnt;
    logic                    r_rw,      w_rw;
    logic                    r_sclk,    w_sclk;
    logic                    r_sen,     w_sen;
    logic                    r_oe,      w_oe;
    logic                    r_busy,    w_busy;
    logic                    r_done,    w_done;
    logic [DATA_BITS-1:0]    r_rdata,   w_rdata;

    logic [FRAME_BITS-1:0]   w_frame;
    logic                    w_cnt_en;
    logic                    w_tick;
    logic                    w_rise;
    logic                    w_fall;

    assign w_frame = build_frame(rw, addr, wdata);

    // The done cycle opens GAP with the timer held, so GAP spans done + CLK_DIV cycles.
    assign w_cnt_en = (r_state != ST_IDLE) && !r_done;

    adc3664_spi_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .en      (w_cnt_en),
        .sclk    (r_sclk),
        .tick    (w_tick),
        .rise    (w_rise),
        .fall    (w_fall)
    );

    // Register the frame state; reset aborts any frame without a done pulse.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= ST_IDLE;
            r_sreg    <= '0;
            r_bit_cnt <= '0;
            r_rw      <= 1'b0;
            r_sclk    <= 1'b0;
            r_sen     <= 1'b1;
            r_oe      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_state   <= w_state;
            r_sreg    <= w_sreg;
            r_bit_cnt <= w_bit_cnt;
            r_rw      <= w_rw;
            r_sclk    <= w_sclk;
            r_sen     <= w_sen;
            r_oe      <= w_oe;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_rdata   <= w_rdata;
        end
    end

    // Next-state and next-output decode; SDIO only moves on SCLK falls.
    always_comb begin
        w_state   = r_state;
        w_sreg    = r_sreg;
        w_bit_cnt = r_bit_cnt;
        w_rw      = r_rw;
        w_sclk    = r_sclk;
        w_sen     = r_sen;
        w_oe      = r_oe;
        w_busy    = r_busy;
        w_done    = 1'b0;
        w_rdata   = r_rdata;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_sreg    = w_frame;
                    w_rw      = rw;
                    w_bit_cnt = '0;
                    w_sclk    = 1'b0;
                    w_sen     = 1'b0;
                    w_oe      = 1'b1;
                    w_busy    = 1'b1;
                    w_state   = ST_LEAD;
                end
            end
            ST_LEAD: begin
                if (w_tick) begin
                    w_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_rise) begin
                    w_sclk    = 1'b1;
                    w_bit_cnt = r_bit_cnt + 1'b1;
                    // Rises 17..24 of a read carry the slave's byte, MSB first.
                    if ((r_rw == RW_READ) && (r_bit_cnt >= BCNT_BITS'(FRAME_BITS - DATA_BITS))) begin
                        w_rdata = {r_rdata[DATA_BITS-2:0], SDIO_in};
                    end
                end else if (w_fall) begin
                    w_sclk = 1'b0;
                    if (r_bit_cnt == BCNT_BITS'(FRAME_BITS)) begin
                        w_state = ST_TRAIL;
                    end else begin
                        w_sreg = {r_sreg[FRAME_BITS-2:0], 1'b0};
                        // Hand SDIO to the slave once the read header is out.
                        if ((r_rw == RW_READ) && (r_bit_cnt == BCNT_BITS'(FRAME_BITS - DATA_BITS))) begin
                            w_oe = 1'b0;
                        end
                    end
                end
            end
            ST_TRAIL: begin
                if (w_tick) begin
                    w_sen   = 1'b1;
                    w_oe    = 1'b0;
                    w_sreg  = '0;
                    w_done  = 1'b1;
                    w_state = ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_tick) begin
                    w_busy  = 1'b0;
                    w_state = ST_IDLE;
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign rdata    = r_rdata;
    assign SCLK     = r_sclk;
    assign SEN      = r_sen;
    assign SDIO_out = r_sreg[FRAME_BITS-1];
    assign SDIO_oe  = r_oe;

endmodule
`default_nettype wire

// File: tb/tb_adc3664_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc3664_spi_master
// Purpose  : Scoreboard bench for adc3664_spi_master with a paired slave
//            register-file model driving SDIO on read frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc3664_spi_master;

    localparam int DIV       = 2;
    localparam int SEN_LOW   = 50 * DIV;
    localparam int BUSY_HIGH = 51 * DIV + 1;

    logic        Clk     = 1'b0;
    logic        Reset_n = 1'b0;
    logic        start   = 1'b0;
    logic        rw      = 1'b0;
    logic [11:0] addr    = '0;
    logic [7:0]  wdata   = '0;
    logic        SDIO_in = 1'b0;
    logic        busy, done, SCLK, SEN, SDIO_out, SDIO_oe;
    logic [7:0]  rdata;

    always #5 Clk = ~Clk;

    adc3664_spi_master #(
        .CLK_DIV (DIV)
    ) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .start    (start),
        .rw       (rw),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .rdata    (rdata),
        .SCLK     (SCLK),
        .SEN      (SEN),
        .SDIO_out (SDIO_out),
        .SDIO_oe  (SDIO_oe),
        .SDIO_in  (SDIO_in)
    );

    typedef struct packed {
        logic        rd;
        logic [23:0] frame;
        logic [7:0]  rdata;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_mem [4096];
    logic [7:0] slave_mem [4096];
    logic [7:0] last_rdata = 8'h00;
    int         n_vec = 0;
    int         n_err = 0;
    int         n_done = 0;
    int         n_expect_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Reference model: frame image plus expected rdata at done.
    task automatic push_exp(input logic r, input logic [11:0] a, input logic [7:0] d);
        exp_t e;
        e.rd    = r;
        e.frame = {r, 3'b000, a, (r ? 8'h00 : d)};
        if (r) last_rdata = model_mem[a];
        else   model_mem[a] = d;
        e.rdata = last_rdata;
        exp_q.push_back(e);
        n_expect_done++;
    endtask

    task automatic wait_idle(input string name);
        int b = 0;
        while (busy && b < 2000) begin
            @(posedge Clk); #1;
            b++;
        end
        chk(name, busy, 0);
    endtask

    task automatic issue(input logic r, input logic [11:0] a, input logic [7:0] d, input bit track);
        wait_idle("idle_before_start");
        rw = r; addr = a; wdata = d; start = 1'b1;
        if (track) push_exp(r, a, d);
        @(posedge Clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("sen_after_start", SEN, 0);
    endtask

    // ---------------- monitor / slave / scoreboard ----------------
    int          m_rise, m_sen_cnt, m_busy_cnt;
    logic [23:0] m_bits;
    logic [11:0] m_addr;
    logic        m_in_frame, m_stable, m_rw;
    logic        p_sen, p_sclk, p_busy, p_out;
    logic        s_rise, s_fall, s_sen_rise;
    exp_t        m_e;

    initial begin
        p_sen = 1'b1; p_sclk = 1'b0; p_busy = 1'b0; p_out = 1'b0;
        m_in_frame = 1'b0; m_busy_cnt = 0; m_rise = 0; m_sen_cnt = 0;
        m_bits = '0; m_addr = '0; m_stable = 1'b1; m_rw = 1'b0;
        forever begin
            @(negedge Clk);
            if (!Reset_n) begin
                m_in_frame = 1'b0; m_busy_cnt = 0;
                p_sen = 1'b1; p_sclk = 1'b0; p_busy = 1'b0; p_out = 1'b0;
                SDIO_in = 1'b0;
            end else begin
                s_rise     = SCLK && !p_sclk;
                s_fall     = !SCLK && p_sclk;
                s_sen_rise = SEN && !p_sen;
                if (busy) m_busy_cnt++;
                if (p_sen && !SEN) begin
                    m_in_frame = 1'b1; m_rise = 0; m_bits = '0; m_sen_cnt = 0;
                    m_stable = 1'b1; m_rw = 1'b0; p_out = SDIO_out;
                end
                if (m_in_frame && !SEN) begin
                    m_sen_cnt++;
                    if ((SDIO_out !== p_out) && !s_fall) m_stable = 1'b0;
                    if (s_rise) begin
                        m_rise++;
                        m_bits = {m_bits[22:0], SDIO_out};
                        if (m_rise == 1)  m_rw = SDIO_out;
                        if (m_rise == 16) m_addr = m_bits[11:0];
                        chk($sformatf("oe_at_rise%0d", m_rise), SDIO_oe,
                            (m_rw && m_rise >= 17) ? 32'd0 : 32'd1);
                    end
                    if (s_fall) begin
                        if (m_rw && m_rise == 16) chk("oe_drop_after_rise16", SDIO_oe, 0);
                        if (m_rw && m_rise >= 16 && m_rise <= 23)
                            SDIO_in = slave_mem[m_addr][23 - m_rise];
                    end
                end
                if (s_sen_rise && m_in_frame) begin
                    chk("done_at_frame_end", done, 1);
                    chk("rise_count", m_rise, 24);
                    chk("sen_low_cycles", m_sen_cnt, SEN_LOW);
                    chk("sdio_change_on_fall_only", m_stable, 1);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", 0, 1);
                    end else begin
                        m_e = exp_q.pop_front();
                        if (m_e.rd) chk("read_header", m_bits[23:8], m_e.frame[23:8]);
                        else        chk("write_frame", m_bits, m_e.frame);
                        chk("rdata_at_done", rdata, m_e.rdata);
                    end
                    if (!m_bits[23]) slave_mem[m_bits[19:8]] = m_bits[7:0];
                    m_in_frame = 1'b0;
                    SDIO_in = 1'b0;
                end
                if (done) begin
                    n_done++;
                    chk("done_with_sen_rise", s_sen_rise, 1);
                end
                if (!SEN && !busy && !done) chk("sen_low_while_idle", 0, 1);
                if (p_busy && !busy) begin
                    chk("busy_high_cycles", m_busy_cnt, BUSY_HIGH);
                    m_busy_cnt = 0;
                end
                p_sen = SEN; p_sclk = SCLK; p_busy = busy; p_out = SDIO_out;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0]  v;
        logic [11:0] a;
        logic        r;
        int          cnt, b, dones_before;
        logic        prev;

        for (int i = 0; i < 4096; i++) begin
            v = 8'($urandom);
            model_mem[i] = v;
            slave_mem[i] = v;
        end
        model_mem[12'hFFF] = 8'hA7;
        slave_mem[12'hFFF] = 8'hA7;

        repeat (3) @(posedge Clk); #1;
        chk("rst_sen", SEN, 1);
        chk("rst_sclk", SCLK, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_oe", SDIO_oe, 0);
        chk("rst_sdo", SDIO_out, 0);
        Reset_n = 1'b1;
        @(posedge Clk); #1;

        // Directed write, read of 0xFFF, read-back of the written register.
        issue(1'b0, 12'h0A5, 8'h3C, 1'b1);
        issue(1'b1, 12'hFFF, 8'h55, 1'b1);
        issue(1'b1, 12'h0A5, 8'h00, 1'b1);

        // A start pulse in mid-frame must be ignored.
        issue(1'b0, 12'h321, 8'h96, 1'b1);
        repeat (10) @(posedge Clk); #1;
        rw = 1'b1; addr = 12'h123; start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        chk("busy_held_on_ignored_start", busy, 1);

        // Reset at SCLK rise 12 aborts the frame with no done.
        issue(1'b0, 12'h5A5, 8'hFF, 1'b0);
        cnt = 0; b = 0; prev = SCLK;
        while (cnt < 12 && b < 1000) begin
            @(posedge Clk); #1;
            if (SCLK && !prev) cnt++;
            prev = SCLK;
            b++;
        end
        chk("reached_rise12", cnt, 12);
        dones_before = n_done;
        Reset_n = 1'b0;
        #1;
        chk("abort_sen", SEN, 1);
        chk("abort_sclk", SCLK, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_oe", SDIO_oe, 0);
        chk("abort_rdata", rdata, 8'h00);
        last_rdata = 8'h00;
        repeat (3) @(posedge Clk); #1;
        Reset_n = 1'b1;
        @(posedge Clk); #1;
        chk("no_done_after_abort", n_done, dones_before);

        issue(1'b0, 12'h0A5, 8'h77, 1'b1);
        issue(1'b1, 12'h5A5, 8'h00, 1'b1);
        issue(1'b1, 12'h0A5, 8'h00, 1'b1);

        // Back-to-back writes with start held high.
        wait_idle("idle_before_b2b");
        rw = 1'b0; addr = 12'h00F; wdata = 8'hE1; start = 1'b1;
        push_exp(1'b0, 12'h00F, 8'hE1);
        @(posedge Clk); #1;
        chk("b2b_busy1", busy, 1);
        addr = 12'hF00; wdata = 8'h1E;
        push_exp(1'b0, 12'hF00, 8'h1E);
        b = 0;
        while (busy && b < 2000) begin @(posedge Clk); #1; b++; end
        b = 0;
        while (!busy && b < 10) begin @(posedge Clk); #1; b++; end
        chk("b2b_second_accepted", busy, 1);
        start = 1'b0;

        // Randomized frames, biased toward boundary addresses.
        for (int k = 0; k < 12; k++) begin
            r = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       a = 12'h000;
                1:       a = 12'hFFF;
                default: a = 12'($urandom);
            endcase
            issue(r, a, 8'($urandom), 1'b1);
        end

        wait_idle("idle_at_end");
        repeat (5) @(posedge Clk); #1;
        chk("queue_empty", exp_q.size(), 0);
        chk("done_count", n_done, n_expect_done);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
